iterative_divider: RTL
======================

Name: iterative_divider

Overview:
- Sequential unsigned radix-2 restoring divider; the inverse arithmetic block to the team's combinational N-bit multiplier.
- Computes quotient and remainder of an N-bit dividend by an N-bit divisor, one quotient bit per clock.
- Sits beside the multiplier in the matrix datapath; used for normalisation and scaling steps.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- N, 32, operand width in bits (dividend, divisor, quotient, remainder); N >= 2.
- CW, $clog2(N), iteration counter width.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- dividend  input  N  unsigned dividend.
- divisor  input  N  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0. Reset takes effect immediately, including mid-CALC or in DONE; any in-flight operation is discarded and produces no result.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at an edge, latch the operands.
  - If divisor==0: go to DONE with quotient={N{1}}, remainder=dividend, div_by_zero=1.
  - Otherwise go to CALC with partial remainder P (N+1 bits)=0, quotient register Q=dividend, counter=N-1, div_by_zero=0.
- CALC:
  - in_ready=0, out_valid=0. Each cycle:
    - T = {P[N-1:0], Q[N-1]} - {1'b0, divisor}.
    - If T is negative (borrow): P={P[N-1:0],Q[N-1]} and Q={Q[N-2:0],0}.
    - Else: P=T and Q={Q[N-2:0],1}.
  - Counter decrements each cycle. The step with counter==0 is the last; then go to DONE.
  - Exactly N CALC cycles.
- DONE:
  - out_valid=1, in_ready=0.
  - quotient=Q, remainder=P[N-1:0]; both stable, with div_by_zero, while out_valid=1 and out_ready=0 (backpressure held indefinitely).
  - On out_valid&out_ready: go to IDLE, out_valid=0 the next cycle. Outputs may hold their last values afterwards.
- Latency, counted from the accept edge to the first edge where out_valid is seen high:
  - N+1 edges for a normal divide (N CALC cycles plus the DONE entry).
  - 1 edge for divide-by-zero.
  - Throughput: one operation per N+2 cycles minimum.
- Operands change while not accepted: ignored. in_valid is irrelevant outside IDLE.
- No accept in the same cycle as a result handshake. A new op is accepted only in IDLE, at the earliest one cycle after out handshake.
- Invariant for nonzero divisor: dividend == quotient*divisor + remainder, and remainder < divisor.
- Combinational paths: none from inputs to outputs. in_ready and out_valid decode directly from state.

Test Plan:
- Reset then 100/7 accepted at edge 0 -> out_valid high after 33 edges (N=32), quotient=14, remainder=2, div_by_zero=0.
- 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0. Then 3/10 -> quotient=0, remainder=3. Then 0x80000000/0x80000000 -> quotient=1, remainder=0.
- 5/0 -> out_valid one cycle after accept, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. A following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- Backpressure: out_ready=0 for 20 cycles in DONE on 1000/33 -> quotient=30, remainder=10 held stable, in_ready=0 throughout. out_ready=1 -> IDLE next cycle.
- Assert rst asynchronously (between edges) mid-CALC at iteration 10 -> out_valid=0, in_ready=1 immediately. No result emitted. Next op 50/8 -> quotient=6, remainder=2.
- Random regression of 10k operand pairs with in_valid/out_ready randomly toggled -> every result matches the golden model (a/b, a%b), with zero-divisor cases per the divide-by-zero rule.

Source files
------------

// File: rtl/iterative_divider.sv
// Sequential unsigned radix-2 restoring divider: one quotient bit per clock,
// valid/ready handshake on operands and results, divide-by-zero flagged.
`timescale 1ns/1ps
module iterative_divider #(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  p_q, p_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;
    logic [N:0]    shifted;
    logic          borrow;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid/ready come straight from state, so nothing depends combinationally on inputs.
    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = q_q;
    assign remainder   = p_q;
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;

    // The partial remainder stays below the divisor, so N bits suffice to hold it.
    assign shifted = {p_q, q_q[N-1]};
    assign borrow  = (shifted < {1'b0, div_q});

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    div_d = divisor;
                    if (divisor == '0) begin
                        q_d     = '1;
                        p_d     = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        q_d     = dividend;
                        p_d     = '0;
                        cnt_d   = CW'(N - 1);
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (borrow) begin
                    p_d = shifted[N-1:0];
                    q_d = {q_q[N-2:0], 1'b0};
                end else begin
                    p_d = shifted[N-1:0] - div_q;
                    q_d = {q_q[N-2:0], 1'b1};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule
